signed_seq_divider: RTL and testbench

Sequential signed divider; the inverse companion of the team's 8x8 array multiplier.
Divides a 16-bit signed dividend by an 8-bit signed divisor.
Produces a 16-bit signed quotient and an 8-bit signed remainder, using the same start/done handshake as the multiplier wrapper.
Radix-2 restoring algorithm on magnitudes, one quotient bit per clock, with a sign fix-up at the end.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_restore_step.sv | 21 ++
 rtl/signed_seq_divider.sv | 127 ++++++++++++
 tb/tb_signed_seq_divider.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the signed sequential divider.
package div_pkg;

   localparam int DVD_W = 16;
   localparam int DVS_W = 8;

   // Capture edge to done-high edge for a nonzero divisor.
   localparam int DIV_LATENCY = 17;

   localparam logic [DVD_W-1:0] DZ_QUOTIENT = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module div_restore_step #(
   parameter int W = 8
) (
   input  logic [W-1:0] rem,
   input  logic         dvd_bit,
   input  logic [W-1:0] dvs,
   output logic [W-1:0] rem_next,
   output logic         q_bit
);

   logic [W:0]   partial;
   logic [W+1:0] diff;

   assign partial = {rem, dvd_bit};
   assign diff    = {1'b0, partial} - {2'b00, dvs};
   assign q_bit   = ~diff[W+1];
   // rem < dvs always holds, so either branch fits back into W bits.
   assign rem_next = q_bit ? diff[W-1:0] : partial[W-1:0];

endmodule

// File: rtl/signed_seq_divider.sv
// Sequential signed divider: 16-bit / 8-bit, one quotient bit per clock.
// Optional SIGNED_SEQ_DIVIDER_SAT_EN saturates overflow and divide-by-zero quotients.
module signed_seq_divider #(
   parameter int DVD_W = div_pkg::DVD_W,
   parameter int DVS_W = div_pkg::DVS_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DVD_W-1:0] a,
   input  logic [DVS_W-1:0] b,
   output logic [DVD_W-1:0] quotient,
   output logic [DVS_W-1:0] remainder,
   output logic             done,
   output logic             busy,
   output logic             dz,
   output logic             ovf
);

   import div_pkg::*;

   localparam int CNT_W = $clog2(DVD_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DVD_W - 1);

   state_t           state, state_next;
   logic [DVD_W-1:0] dvd_r;
   logic [DVS_W-1:0] rem_r;
   logic [DVS_W-1:0] dvs_r;
   logic [CNT_W-1:0] count;
   logic             sign_q, sign_r, dz_pend;
   logic             capture;
   logic [DVS_W-1:0] rem_next;
   logic             q_bit;
   logic [DVD_W-1:0] a_mag;
   logic [DVS_W-1:0] b_mag;
   logic             b_zero;
   logic [DVD_W-1:0] quotient_fix;
   logic [DVS_W-1:0] remainder_fix;
   logic             ovf_fix;

   // The done-fall edge also samples start, giving one result per 18 cycles.
   assign capture = start && (state == IDLE || state == DONE);
   assign b_zero  = (b == '0);
   assign a_mag   = a[DVD_W-1] ? (~a + 1'b1) : a;
   assign b_mag   = b[DVS_W-1] ? (~b + 1'b1) : b;

   div_restore_step #(.W(DVS_W)) u_step (
      .rem      (rem_r),
      .dvd_bit  (dvd_r[DVD_W-1]),
      .dvs      (dvs_r),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: begin
            if (capture) state_next = b_zero ? FIX : CALC;
            else         state_next = IDLE;
         end
         CALC:    if (count == LAST) state_next = FIX;
         FIX:     state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      done          = (state == DONE);
      busy          = (state != IDLE);
      // Only -32768 / -1 yields a positive magnitude with the top bit set.
      ovf_fix       = !dz_pend && !sign_q && dvd_r[DVD_W-1];
      quotient_fix  = sign_q ? (~dvd_r + 1'b1) : dvd_r;
      remainder_fix = sign_r ? (~rem_r + 1'b1) : rem_r;
`ifdef SIGNED_SEQ_DIVIDER_SAT_EN
      if (ovf_fix) quotient_fix = {1'b0, {(DVD_W-1){1'b1}}};
`endif
      if (dz_pend) begin
`ifdef SIGNED_SEQ_DIVIDER_SAT_EN
         quotient_fix = sign_r ? {1'b1, {(DVD_W-1){1'b0}}} : {1'b0, {(DVD_W-1){1'b1}}};
`else
         quotient_fix = DVD_W'(DZ_QUOTIENT);
`endif
         remainder_fix = rem_r;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dvd_r     <= '0;
         rem_r     <= '0;
         dvs_r     <= '0;
         count     <= '0;
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
         dz_pend   <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         dz        <= 1'b0;
         ovf       <= 1'b0;
      end else if (capture) begin
         dvd_r   <= a_mag;
         dvs_r   <= b_mag;
         // A zero divisor skips CALC; the low dividend byte is its remainder.
         rem_r   <= b_zero ? a[DVS_W-1:0] : '0;
         count   <= '0;
         sign_q  <= a[DVD_W-1] ^ b[DVS_W-1];
         sign_r  <= a[DVD_W-1];
         dz_pend <= b_zero;
      end else if (state == CALC) begin
         dvd_r <= {dvd_r[DVD_W-2:0], q_bit};
         rem_r <= rem_next;
         count <= count + 1'b1;
      end else if (state == FIX) begin
         quotient  <= quotient_fix;
         remainder <= remainder_fix;
         dz        <= dz_pend;
         ovf       <= ovf_fix;
      end
   end

endmodule

// File: tb/tb_signed_seq_divider.sv
// Directed bench for signed_seq_divider with a scoreboard of expected results.
module tb_signed_seq_divider;

   localparam int DVD_W = 16;
   localparam int DVS_W = 8;
   localparam int EXP_W = DVD_W + DVS_W + 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [DVD_W-1:0] a = '0;
   logic [DVS_W-1:0] b = '0;
   logic [DVD_W-1:0] quotient;
   logic [DVS_W-1:0] remainder;
   logic             done, busy, dz, ovf;

   logic [EXP_W-1:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int done_count = 0;

   always #5 clk = ~clk;

   signed_seq_divider dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .quotient  (quotient),
      .remainder (remainder),
      .done      (done),
      .busy      (busy),
      .dz        (dz),
      .ovf       (ovf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference model: {quotient, remainder, dz, ovf}.
   function automatic logic [EXP_W-1:0] model(input logic [DVD_W-1:0] av, input logic [DVS_W-1:0] bv);
      logic [DVD_W-1:0] q;
      logic [DVS_W-1:0] r;
      logic             z, o;
      int               ai, bi;
      ai = int'($signed(av));
      bi = int'($signed(bv));
      z = 1'b0;
      o = 1'b0;
      if (bi == 0) begin
         z = 1'b1;
`ifdef SIGNED_SEQ_DIVIDER_SAT_EN
         q = (ai < 0) ? 16'h8000 : 16'h7FFF;
`else
         q = 16'hFFFF;
`endif
         r = av[DVS_W-1:0];
      end else if (ai == -32768 && bi == -1) begin
         o = 1'b1;
`ifdef SIGNED_SEQ_DIVIDER_SAT_EN
         q = 16'h7FFF;
`else
         q = 16'h8000;
`endif
         r = '0;
      end else begin
         q = DVD_W'(ai / bi);
         r = DVS_W'(ai % bi);
      end
      return {q, r, z, o};
   endfunction

   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      if (!rst && done) begin
         done_count++;
         n_cmp++;
         assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL unexpected_done observed=%0h expected=none", quotient);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("quotient", 32'(quotient), 32'(e[EXP_W-1 -: DVD_W]));
            check("remainder", 32'(remainder), 32'(e[DVS_W+1 -: DVS_W]));
            check("dz", 32'(dz), 32'(e[1]));
            check("ovf", 32'(ovf), 32'(e[0]));
         end
      end
   end

   task automatic run_op(input logic [DVD_W-1:0] av, input logic [DVS_W-1:0] bv, input int lat,
                         input int busy_exp);
      int j, busy_n;
      @(negedge clk);
      a = av;
      b = bv;
      start = 1'b1;
      exp_q.push_back(model(av, bv));
      @(negedge clk);
      start = 1'b0;
      a = 16'(($urandom_range(0, 65535)));
      b = 8'($urandom_range(0, 255));
      j = 0;
      busy_n = busy ? 1 : 0;
      while (!done && j < 60) begin
         @(negedge clk);
         j++;
         if (busy) busy_n++;
      end
      check("latency", 32'(j), 32'(lat));
      if (busy_exp > 0) check("busy_cycles", 32'(busy_n), 32'(busy_exp));
      @(negedge clk);
      check("done_fall", 32'(done), 32'd0);
      check("busy_fall", 32'(busy), 32'd0);
   endtask

   initial begin
      int j;
      int dc;
      logic [DVD_W-1:0] ra;
      logic [DVS_W-1:0] rb;

      repeat (2) @(negedge clk);
      check("rst_quotient", 32'(quotient), 32'd0);
      check("rst_remainder", 32'(remainder), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_dz", 32'(dz), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      rst = 1'b0;

      run_op(16'd1000, 8'd20, 17, 18);
      run_op(16'd1000, -8'sd7, 17, 18);
      run_op(-16'sd1000, 8'd7, 17, 0);
      run_op(-16'sd1000, -8'sd7, 17, 0);
      run_op(16'h8000, 8'hFF, 17, 0);
      run_op(16'h8000, 8'h80, 17, 0);
      run_op(16'h8000, 8'd1, 17, 0);
      run_op(16'd5, 8'd0, 1, 2);
      run_op(-16'sd300, 8'd0, 1, 0);
      run_op(16'h7FFF, 8'h80, 17, 0);
      for (int i = 0; i < 6; i++) begin
         ra = 16'($urandom_range(0, 65535));
         rb = 8'($urandom_range(0, 255));
         run_op(ra, rb, (rb == '0) ? 1 : 17, 0);
      end

      // Held start: a changes mid-operation, next capture at the done-fall edge.
      @(negedge clk);
      a = 16'd300;
      b = 8'd7;
      start = 1'b1;
      exp_q.push_back(model(16'd300, 8'd7));
      @(negedge clk);
      j = 0;
      repeat (5) begin
         @(negedge clk);
         j++;
      end
      a = 16'd100;
      while (!done && j < 60) begin
         @(negedge clk);
         j++;
      end
      check("b2b_latency1", 32'(j), 32'd17);
      exp_q.push_back(model(16'd100, 8'd7));
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy", 32'(busy), 32'd1);
      check("b2b_done_low", 32'(done), 32'd0);
      j = 0;
      while (!done && j < 60) begin
         @(negedge clk);
         j++;
      end
      check("b2b_latency2", 32'(j), 32'd17);
      @(negedge clk);
      check("b2b_idle", 32'(busy), 32'd0);

      // Reset while CALC holds count 8: no done, outputs cleared.
      @(negedge clk);
      a = 16'd1234;
      b = 8'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      check("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_quotient", 32'(quotient), 32'd0);
      check("mid_rst_remainder", 32'(remainder), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      dc = done_count;
      repeat (25) @(negedge clk);
      check("no_done_after_rst", 32'(done_count), 32'(dc));
      run_op(16'd81, 8'd9, 17, 18);

      repeat (3) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
